// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared types and constants for the Collatz record tracker
package collatz_pkg;

    localparam int DEF_BITS      = 32;
    localparam int DEF_STEP_BITS = 16;

    localparam int FLAG_STEPS = 0;
    localparam int FLAG_PEAK  = 1;

    typedef enum logic {
        UNARMED = 1'b0,
        RUN     = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_BITS-1:0]      start;
        logic [DEF_STEP_BITS-1:0] steps;
        logic [DEF_BITS-1:0]      peak;
        logic [1:0]               flags;
    } collatz_event_t;

endpackage

// File: rtl/collatz_event_fifo.sv
// rtl/collatz_event_fifo.sv - synchronous event FIFO with push-while-full-and-popping support
module collatz_event_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = 1;

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_one;
            if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= push_data;
    end

endmodule

// File: rtl/collatz_record_tracker.sv
// rtl/collatz_record_tracker.sv - Collatz trajectory record tracker with event FIFO; peak tracking under COLLATZ_PEAK_TRACK_EN
module collatz_record_tracker
    import collatz_pkg::*;
#(
    parameter int bits       = DEF_BITS,
    parameter int step_bits  = DEF_STEP_BITS,
    parameter int fifo_depth = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic [bits-1:0]      start,
    input  logic [bits-1:0]      actual,
    output logic [step_bits-1:0] cur_steps,
    output logic [step_bits-1:0] rec_steps,
    output logic [bits-1:0]      rec_steps_start,
    output logic [bits-1:0]      rec_peak,
    output logic [bits-1:0]      rec_peak_start,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [bits-1:0]      ev_start,
    output logic [step_bits-1:0] ev_steps,
    output logic [bits-1:0]      ev_peak,
    output logic [1:0]           ev_flags,
    output logic                 ev_lost
);

`ifdef COLLATZ_PEAK_TRACK_EN
    localparam int ew = 2 * bits + step_bits + 2;
`else
    localparam int ew = bits + step_bits + 1;
`endif

    state_t          state, state_next;
    logic [bits-1:0] start_q;
    logic            boundary;
    logic            step_brk;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ew-1:0]   push_data;
    logic [ew-1:0]   head;

`ifdef COLLATZ_PEAK_TRACK_EN
    logic [bits-1:0] peak_q;
    logic            peak_brk;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= UNARMED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        boundary   = 1'b0;
        step_brk   = 1'b0;
`ifdef COLLATZ_PEAK_TRACK_EN
        peak_brk   = 1'b0;
`endif
        if (clken) begin
            if (state == UNARMED) begin
                state_next = RUN;
            end else if (start != start_q) begin
                boundary = 1'b1;
                step_brk = (cur_steps > rec_steps);
`ifdef COLLATZ_PEAK_TRACK_EN
                peak_brk = (peak_q > rec_peak);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q         <= '0;
            cur_steps       <= '0;
            rec_steps       <= '0;
            rec_steps_start <= '0;
        end else if (clken) begin
            if (state == UNARMED || boundary) begin
                start_q   <= start;
                cur_steps <= '0;
            end else if (cur_steps != {step_bits{1'b1}}) begin
                cur_steps <= cur_steps + 1'b1;
            end
            if (step_brk) begin
                rec_steps       <= cur_steps;
                rec_steps_start <= start_q;
            end
        end
    end

`ifdef COLLATZ_PEAK_TRACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q         <= '0;
            rec_peak       <= '0;
            rec_peak_start <= '0;
        end else if (clken) begin
            if (state == UNARMED || boundary) peak_q <= actual;
            else if (actual > peak_q)         peak_q <= actual;
            if (peak_brk) begin
                rec_peak       <= peak_q;
                rec_peak_start <= start_q;
            end
        end
    end

    assign push      = step_brk | peak_brk;
    assign push_data = {start_q, cur_steps, peak_q, peak_brk, step_brk};
    assign ev_start  = head[ew-1 -: bits];
    assign ev_steps  = head[bits+2 +: step_bits];
    assign ev_peak   = head[2 +: bits];
    assign ev_flags  = head[1:0];
`else
    logic unused_actual;
    assign unused_actual  = ^actual;
    assign rec_peak       = '0;
    assign rec_peak_start = '0;
    assign push           = step_brk;
    assign push_data      = {start_q, cur_steps, step_brk};
    assign ev_start       = head[ew-1 -: bits];
    assign ev_steps       = head[1 +: step_bits];
    assign ev_peak        = '0;
    assign ev_flags       = {1'b0, head[FLAG_STEPS]};
`endif

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid & ev_ready;

    collatz_event_fifo #(
        .width(ew),
        .depth(fifo_depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A push refused by a full FIFO with no simultaneous pop is lost for good.
    always_ff @(posedge clk) begin
        if (reset)                          ev_lost <= 1'b0;
        else if (push && fifo_full && !pop) ev_lost <= 1'b1;
    end

endmodule

// File: tb/tb_collatz_record_tracker.sv
// tb/tb_collatz_record_tracker.sv - directed self-checking bench for collatz_record_tracker
module tb_collatz_record_tracker;
    import collatz_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b0;
    logic [31:0] start = '0;
    logic [31:0] actual = '0;
    logic [15:0] cur_steps, rec_steps;
    logic [31:0] rec_steps_start, rec_peak, rec_peak_start;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [31:0] ev_start, ev_peak;
    logic [15:0] ev_steps;
    logic [1:0]  ev_flags;
    logic        ev_lost;

    int tests = 0;
    int fails = 0;
    collatz_event_t exp_q[$];

    always #5 clk = ~clk;

    collatz_record_tracker #(.bits(32), .step_bits(16), .fifo_depth(4)) dut (
        .clk(clk), .reset(reset), .clken(clken), .start(start), .actual(actual),
        .cur_steps(cur_steps), .rec_steps(rec_steps), .rec_steps_start(rec_steps_start),
        .rec_peak(rec_peak), .rec_peak_start(rec_peak_start),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_start(ev_start),
        .ev_steps(ev_steps), .ev_peak(ev_peak), .ev_flags(ev_flags), .ev_lost(ev_lost)
    );

    function automatic logic [31:0] ep(input logic [31:0] v);
`ifdef COLLATZ_PEAK_TRACK_EN
        return v;
`else
        return '0 & v;
`endif
    endfunction

    function automatic logic [1:0] ef(input logic [1:0] f);
`ifdef COLLATZ_PEAK_TRACK_EN
        return f;
`else
        return {1'b0, f[FLAG_STEPS]};
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clken = 1'b0;
        ev_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic sample(input logic [31:0] s, input logic [31:0] a);
        start = s;
        actual = a;
        clken = 1'b1;
        @(posedge clk);
        #1 clken = 1'b0;
    endtask

    task automatic head_chk(input string tag, input logic [31:0] s, input logic [15:0] st,
                            input logic [31:0] pk, input logic [1:0] fl);
        chk({tag, "_valid"}, ev_valid, 1'b1);
        chk({tag, "_start"}, ev_start, s);
        chk({tag, "_steps"}, ev_steps, st);
        chk({tag, "_peak"},  ev_peak,  pk);
        chk({tag, "_flags"}, ev_flags, fl);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] s, input logic [15:0] st,
                           input logic [31:0] pk, input logic [1:0] fl);
        head_chk(tag, s, st, pk, fl);
        ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_cur_steps", cur_steps, 0);
        chk("rst_rec_steps", rec_steps, 0);
        chk("rst_rec_steps_start", rec_steps_start, 0);
        chk("rst_rec_peak", rec_peak, 0);
        chk("rst_rec_peak_start", rec_peak_start, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_lost", ev_lost, 0);

        // Scenario 1: start=2 arms, start=3 runs 3,5,8,4,2, start=4 finalizes it
        sample(2, 2);
        chk("arm_cur_steps", cur_steps, 0);
        chk("arm_no_event", ev_valid, 0);
        sample(3, 3); sample(3, 5); sample(3, 8); sample(3, 4); sample(3, 2);
        chk("s1_cur_steps", cur_steps, 4);
        sample(4, 4);
        chk("s1_rec_steps", rec_steps, 4);
        chk("s1_rec_steps_start", rec_steps_start, 3);
        chk("s1_rec_peak", rec_peak, ep(8));
        chk("s1_rec_peak_start", rec_peak_start, ep(3));
`ifdef COLLATZ_PEAK_TRACK_EN
        pop_chk("s1_ev_peak_only", 2, 0, 2, 2'b10);
`endif
        pop_chk("s1_ev", 3, 4, ep(8), ef(2'b11));
        chk("s1_drained", ev_valid, 0);

        // Scenario 2: tie on steps and peak keeps the earlier records
        sample(5, 5); sample(5, 8); sample(5, 4); sample(5, 2); sample(5, 1);
        chk("s2_cur_steps", cur_steps, 4);
        start = 99;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_cur_steps", cur_steps, 4);
        chk("hold_no_event", ev_valid, 0);

        // Scenario 3: six step records into a 4-deep FIFO with no consumer
        for (int k = 0; k < 6; k++) begin
            for (int n = 0; n <= 5 + k; n++) sample(32'(10 + k), 1);
            if (k == 0) begin
                chk("tie_no_event", ev_valid, 0);
                chk("tie_rec_start", rec_steps_start, 3);
            end
            if (k == 4) chk("s3_full_no_loss", ev_lost, 0);
        end
        sample(16, 1);
        chk("s3_ev_lost", ev_lost, 1);
        chk("s3_rec_steps", rec_steps, 10);
        chk("s3_rec_steps_start", rec_steps_start, 15);
        chk("s3_rec_peak_kept", rec_peak, ep(8));
        for (int k = 0; k < 4; k++) exp_q.push_back('{start: 32'(10 + k), steps: 16'(5 + k), peak: ep(1), flags: 2'b01});
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            head_chk("s3_b2b", exp_q[0].start, exp_q[0].steps, exp_q[0].peak, exp_q[0].flags);
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        ev_ready = 1'b0;
        chk("s3_drained", ev_valid, 0);

        // Scenario 4: push coinciding with a pop on a full FIFO
        do_reset();
        sample(20, 0); sample(20, 0);
        for (int s = 21; s <= 24; s++)
            for (int n = 0; n <= s - 19; n++) sample(32'(s), 0);
        chk("s4_full_valid", ev_valid, 1);
        chk("s4_full_no_loss", ev_lost, 0);
        head_chk("s4_head0", 20, 1, 0, 2'b01);
        ev_ready = 1'b1;
        sample(25, 0);
        ev_ready = 1'b0;
        chk("s4_coincident_no_loss", ev_lost, 0);
        pop_chk("s4_ev21", 21, 2, 0, 2'b01);
        pop_chk("s4_ev22", 22, 3, 0, 2'b01);
        pop_chk("s4_ev23", 23, 4, 0, 2'b01);
        pop_chk("s4_ev24", 24, 5, 0, 2'b01);
        chk("s4_drained", ev_valid, 0);

        // Scenario 5: step counter saturation
        do_reset();
        sample(30, 0);
        start = 30;
        actual = 0;
        clken = 1'b1;
        repeat (70000) @(posedge clk);
        #1 clken = 1'b0;
        chk("sat_cur_steps", cur_steps, 16'hffff);
        chk("sat_no_event", ev_valid, 0);

        // Scenario 6: reset mid-trajectory discards it, next sample only arms
        do_reset();
        chk("mid_rst_cur_steps", cur_steps, 0);
        sample(40, 5);
        chk("rearm_no_event", ev_valid, 0);
        chk("rearm_rec_steps", rec_steps, 0);
        chk("rearm_rec_peak", rec_peak, 0);
        chk("rearm_cur_steps", cur_steps, 0);
        sample(40, 7);
        chk("rearm_step1", cur_steps, 1);
        sample(41, 1);
        pop_chk("s6_ev", 40, 1, ep(7), ef(2'b11));
        chk("s6_rec_peak", rec_peak, ep(7));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
